alu_sequencer: RTL
==================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter ALU_LAT, default 0: extra wait cycles between driving ALU inputs and sampling ALU outputs, range 0..3.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  sequencer accepts a request this cycle.
REQ-006 req_op  input  2  operation code:
- 0: ~b
- 1: a&b
- 2: a|b
- 3: a+b
REQ-007 req_a, req_b  input  8  operands.
REQ-008 rsp_valid  output  1  response present.
REQ-009 rsp_ready  input  1  consumer accepts response.
REQ-010 rsp_data  output  8  8-bit result.
REQ-011 rsp_carry  output  1  carry out of the 8-bit add; 0 for ops 0-2.
REQ-012 alu_sel  output  2  to the 4-bit ALU select.
REQ-013 alu_a, alu_b  output  4  to the 4-bit ALU operands.
REQ-014 alu_c  input  4  ALU result.
REQ-015 alu_carry  input  1  ALU carry.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 The block SHALL execute one 8-bit op as sequential 4-bit passes through the external combinational ALU.
REQ-018 FSM states SHALL be IDLE, LO, HI, INC, RESP.
REQ-019 req_ready SHALL be 1 only in IDLE; a handshake is req_valid&req_ready.
- On handshake, latch op/a/b.
- Clear result and carry flags.
- Go to LO.
REQ-020 In LO, the block SHALL drive:
- alu_sel=op, alu_a=a[3:0], alu_b=b[3:0].
- After ALU_LAT wait cycles, sample res[3:0]=alu_c and cy_lo=alu_carry, then go to HI.
REQ-021 In HI, the block SHALL drive:
- alu_sel=op, alu_a=a[7:4], alu_b=b[7:4].
- After ALU_LAT waits, sample res[7:4]=alu_c and cy_hi=alu_carry.
- Go to INC if op==3 and cy_lo==1, else RESP.
REQ-022 In INC, the block SHALL drive:
- alu_sel=3, alu_a=res[7:4], alu_b=4'd1.
- After ALU_LAT waits, sample res[7:4]=alu_c and cy_inc=alu_carry, then go to RESP.
REQ-023 A wait counter SHALL reload to ALU_LAT on each pass entry; ALU inputs SHALL be held stable for the whole pass.
REQ-024 In IDLE and RESP, alu_sel, alu_a and alu_b SHALL be 0.
REQ-025 In RESP, the outputs SHALL be:
- rsp_valid=1, rsp_data=res.
- rsp_carry=(op==3)&(cy_hi|cy_inc).
- All held stable until rsp_valid&rsp_ready, then go to IDLE.
REQ-026 Latency from handshake cycle T to first rsp_valid SHALL be T+3+2*ALU_LAT without INC, and T+4+3*ALU_LAT with INC.
REQ-027 For op 0, req_a SHALL be ignored; for ops 0-2, alu_carry SHALL be ignored.
REQ-028 Throughput is one request per response; a new request SHALL NOT be accepted in the cycle of the response handshake (ready only in IDLE).
REQ-029 req_valid SHALL be ignored in all states other than IDLE.

Reset
REQ-030 When rst=1 at a clock edge, the block SHALL set:
- state=IDLE, req_ready=1, rsp_valid=0, rsp_data=0, rsp_carry=0.
- alu_sel/alu_a/alu_b=0, busy=0, internal flags cleared.
REQ-031 Reset mid-operation (any state) SHALL abort the op with no response emitted; rst overrides simultaneous req/rsp handshakes.

Verification
Bench uses a behavioral ALU: sel0 ~b, sel1 and, sel2 or, sel3 {carry,c}=a+b; ALU_LAT=0 unless stated.
REQ-032 op=1, a=0xF0, b=0x3C at T -> rsp_valid at T+3, rsp_data=0x30, rsp_carry=0.
REQ-033 op=0, a=0x77, b=0x5A -> rsp_data=0xA5, rsp_carry=0, no INC pass.
REQ-034 op=3, a=0x0F, b=0x01 -> INC pass taken, rsp_valid at T+4, rsp_data=0x10, rsp_carry=0.
REQ-035 Wrap-around and latency with op=3, a=0xFF, b=0x01:
- rsp_data=0x00, rsp_carry=1.
- With ALU_LAT=2, rsp_valid at T+10.
REQ-036 Backpressure and reset during a request:
- Hold rsp_ready=0 for 3 cycles in RESP -> rsp_data/rsp_carry stable, req_ready=0, new req_valid ignored.
- Assert rst during HI -> next cycle IDLE, rsp_valid never asserts for that request.

Source files
------------

// File: rtl/alu_sequencer.sv
// Runs one 8-bit operation as 4-bit passes through an external combinational ALU.
// An add whose low nibble carries out gets an extra increment pass on the high nibble.
module alu_sequencer #(
  parameter int ALU_LAT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_carry,
  output logic [1:0] alu_sel,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  input  logic [3:0] alu_c,
  input  logic       alu_carry,
  output logic       busy
);

  localparam logic [1:0] OP_ADD = 2'd3;
  localparam logic [1:0] LAT    = 2'(ALU_LAT);

  typedef enum logic [2:0] {IDLE, LO, HI, INC, RESP} state_t;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] res;
  logic       cy_lo;
  logic       cy_hi;
  logic       cy_inc;
  logic [1:0] wait_cnt;
  logic       in_pass;
  logic       pass_done;

  assign in_pass   = (state == LO) || (state == HI) || (state == INC);
  assign pass_done = (wait_cnt == 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operands and result are only observed inside an operation, so only control is reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cy_lo    <= 1'b0;
      cy_hi    <= 1'b0;
      cy_inc   <= 1'b0;
      wait_cnt <= LAT;
    end else if (state == IDLE) begin
      if (req_valid) begin
        op       <= req_op;
        a        <= req_a;
        b        <= req_b;
        res      <= 8'd0;
        cy_lo    <= 1'b0;
        cy_hi    <= 1'b0;
        cy_inc   <= 1'b0;
        wait_cnt <= LAT;
      end
    end else if (in_pass) begin
      if (pass_done) begin
        wait_cnt <= LAT;
        unique case (state)
          LO: begin
            res[3:0] <= alu_c;
            cy_lo    <= alu_carry;
          end
          HI: begin
            res[7:4] <= alu_c;
            cy_hi    <= alu_carry;
          end
          INC: begin
            res[7:4] <= alu_c;
            cy_inc   <= alu_carry;
          end
          default: ;
        endcase
      end else begin
        wait_cnt <= wait_cnt - 2'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (req_valid) state_nxt = LO;
      LO:   if (pass_done) state_nxt = HI;
      HI:   if (pass_done) state_nxt = ((op == OP_ADD) && cy_lo) ? INC : RESP;
      INC:  if (pass_done) state_nxt = RESP;
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ALU inputs depend only on state and latched values, so they hold for a whole pass.
  always_comb begin
    req_ready = 1'b0;
    busy      = 1'b1;
    rsp_valid = 1'b0;
    rsp_data  = 8'd0;
    rsp_carry = 1'b0;
    alu_sel   = 2'd0;
    alu_a     = 4'd0;
    alu_b     = 4'd0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      LO: begin
        alu_sel = op;
        alu_a   = a[3:0];
        alu_b   = b[3:0];
      end
      HI: begin
        alu_sel = op;
        alu_a   = a[7:4];
        alu_b   = b[7:4];
      end
      INC: begin
        alu_sel = OP_ADD;
        alu_a   = res[7:4];
        alu_b   = 4'd1;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_data  = res;
        rsp_carry = (op == OP_ADD) && (cy_hi || cy_inc);
      end
      default: ;
    endcase
  end

endmodule
